// File: rtl/uart_pkg.sv
// Shared definitions for the matrix UART link (receiver and transmitter).
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } uart_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned ROWS = 2;
  localparam int unsigned COLS = 4;

  // Widest data word the parity helper accepts; zero-extension does not change the XOR.
  localparam int unsigned PAR_MAX_W = 32;

  // Parity bit a sender must append so that the frame satisfies the selected mode.
  function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] data, input int unsigned mode);
    logic x;
    x = ^data;
    case (mode)
      PAR_ODD:  parity_bit = ~x;
      PAR_EVEN: parity_bit = x;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period pacer: free-running CLKS_PER_BIT counter restarted by start_i,
// with registered half-period and full-period ticks.
module uart_rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic half_o,
  output logic full_o
);

  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          half_q, full_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (start_i || (cnt_q == CW'(CLKS_PER_BIT - 1))) begin
      cnt_d = '0;
    end
  end

  // Ticks are registered from the next count so they line up with cnt_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= (cnt_d == CW'(HALF - 1));
      full_q <= (cnt_d == CW'(CLKS_PER_BIT - 1));
    end
  end

  assign half_o = half_q;
  assign full_o = full_q;

endmodule

// File: rtl/uart_matrix_rx.sv
// Matrix UART receiver: 8 frames into a 2x4 row-major byte matrix with a read port.
// Optional idle timeout / flag clearing via `define UART_RX_TIMEOUT_EN. rx is assumed synchronous to clk.
module uart_matrix_rx
  import uart_pkg::*;
#(
  parameter int unsigned W            = 8,
  parameter int unsigned PAR          = 0,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned TIMEOUT_BITS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  input  logic         row,
  input  logic [1:0]   col,
  output logic [W-1:0] r_cell,
  output logic         r_busy,
  output logic         done,
  output logic         par_err,
  output logic         frm_err
);

`ifdef UART_RX_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int unsigned NCELLS    = ROWS * COLS;
  localparam int unsigned IW        = $clog2(NCELLS);
  localparam int unsigned BW        = $clog2(W + 1);
  localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TW        = $clog2(TO_CYCLES + 1);
  localparam bit          PAR_EN    = (PAR == PAR_ODD) || (PAR == PAR_EVEN);

  uart_state_e   state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic          pend_q, pend_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          done_q, done_d;
  logic          par_err_q, par_err_d;
  logic          frm_err_q, frm_err_d;
  logic          busy_q;
  logic          wr_en;
  logic          tmr_start, tick_half, tick_full;
  logic [W-1:0]  cells_q [NCELLS];

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start_i(tmr_start),
    .half_o (tick_half),
    .full_o (tick_full)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    idle_cnt_d = '0;
    done_d     = 1'b0;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    wr_en      = 1'b0;
    tmr_start  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmr_start = 1'b1;
        if (!rx) begin
          state_d  = S_START;
          bitcnt_d = '0;
          pend_d   = 1'b0;
          if (TIMEOUT_EN && (idx_q == '0)) begin
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
          end
        end else if (TIMEOUT_EN && (idx_q != '0)) begin
          if (idle_cnt_q == TW'(TO_CYCLES - 1)) begin
            idx_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
          end
        end
      end

      S_START: begin
        if (tick_half) begin
          if (rx) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            tmr_start = 1'b1;
          end
        end
      end

      S_DATA: begin
        if (tick_full) begin
          shreg_d  = {rx, shreg_q[W-1:1]};
          bitcnt_d = bitcnt_q + BW'(1);
          if (bitcnt_q == BW'(W - 1)) begin
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (tick_full) begin
          pend_d  = (rx != parity_bit(PAR_MAX_W'(shreg_q), PAR));
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (tick_full) begin
          if (rx) begin
            state_d = S_IDLE;
            if (pend_q) begin
              par_err_d = 1'b1;
            end else begin
              wr_en  = 1'b1;
              idx_d  = idx_q + IW'(1);
              done_d = (idx_q == IW'(NCELLS - 1));
            end
          end else begin
            frm_err_d = 1'b1;
            state_d   = S_WAIT_HIGH;
          end
        end
      end

      // A stuck-low line after a bad stop bit must not look like a new start bit.
      S_WAIT_HIGH: begin
        tmr_start = 1'b1;
        if (rx) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      pend_q     <= 1'b0;
      idx_q      <= '0;
      idle_cnt_q <= '0;
      done_q     <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < int'(NCELLS); i++) begin
        cells_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      idle_cnt_q <= idle_cnt_d;
      done_q     <= done_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      busy_q     <= (state_d != S_IDLE);
      if (wr_en) begin
        cells_q[idx_q] <= shreg_q;
      end
    end
  end

  // Read port sees the registered cells, so a same-cycle write returns the old value.
  assign r_cell  = cells_q[IW'({row, col})];
  assign r_busy  = busy_q;
  assign done    = done_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_matrix_rx.sv
// Directed + randomized bench for uart_matrix_rx against a frame-level matrix model.
module tb_uart_matrix_rx;

  localparam int unsigned TB_W       = 8;
  localparam int unsigned TB_PAR     = 2;
  localparam int unsigned TB_CPB     = 4;
  localparam int unsigned TB_TIMEOUT = 16;
`ifdef UART_RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            rx;
  logic            row;
  logic [1:0]      col;
  logic [TB_W-1:0] r_cell;
  logic            r_busy;
  logic            done;
  logic            par_err;
  logic            frm_err;

  int n_cmp;
  int n_fail;

  logic [7:0] m_cells [8];
  int         m_idx;
  bit         m_par;
  bit         m_frm;
  int         exp_done;

  int done_rise;
  int done_hi;
  bit done_prev;

  uart_matrix_rx #(
    .W(TB_W), .PAR(TB_PAR), .CLKS_PER_BIT(TB_CPB), .TIMEOUT_BITS(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .row(row), .col(col),
    .r_cell(r_cell), .r_busy(r_busy), .done(done),
    .par_err(par_err), .frm_err(frm_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    done_rise = 0;
    done_hi   = 0;
    done_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_hi++;
      if (!done_prev) done_rise++;
    end
    done_prev = (done === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference rules: odd -> XOR(data,p)==1, even -> XOR(data,p)==0.
  function automatic logic model_par(input logic [7:0] b);
    if (TB_PAR == 1) return ~(^b);
    if (TB_PAR == 2) return ^b;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cells[i] = 8'h00;
    m_idx = 0;
    m_par = 1'b0;
    m_frm = 1'b0;
  endtask

  task automatic model_start();
    if (TO_EN && m_idx == 0) begin
      m_par = 1'b0;
      m_frm = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    model_start();
    if (bad_stop) m_frm = 1'b1;
    else if (bad_par && TB_PAR != 0) m_par = 1'b1;
    else begin
      m_cells[m_idx] = b;
      if (m_idx == 7) exp_done++;
      m_idx = (m_idx + 1) % 8;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (TB_CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int gap_bits);
    model_frame(b, bad_par, bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (TB_PAR != 0) drive_bit(model_par(b) ^ bad_par);
    drive_bit(!bad_stop);
    for (int i = 0; i < gap_bits; i++) drive_bit(1'b1);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
    if (TO_EN && n >= int'(TB_TIMEOUT)) m_idx = 0;
  endtask

  task automatic check_matrix(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      row = 1'(i / 4);
      col = 2'(i % 4);
      #1;
      check($sformatf("%s_cell%0d", tag, i), 32'(r_cell), 32'(m_cells[i]));
    end
    @(negedge clk);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_par_err"}, 32'(par_err), 32'(m_par));
    check({tag, "_frm_err"}, 32'(frm_err), 32'(m_frm));
  endtask

  logic [7:0] old_v;
  logic [7:0] prev_v;
  bit         seen;
  int         busy_cnt;

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    exp_done = 0;
    rst = 1'b1;
    rx  = 1'b1;
    row = 1'b0;
    col = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_busy", 32'(r_busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_flags("rst");
    check_matrix("rst");

    // Bytes 1..8 back-to-back; watch the write/read collision on cell (1,3)
    for (int i = 0; i < 7; i++) send_frame(8'(i + 1), 1'b0, 1'b0, 0);
    row = 1'b1;
    col = 2'd3;
    old_v = m_cells[7];
    fork
      send_frame(8'd8, 1'b0, 1'b0, 1);
      begin : watch_done
        seen   = 1'b0;
        prev_v = r_cell;
        for (int k = 0; k < 80 && !seen; k++) begin
          @(negedge clk);
          if (done === 1'b1) begin
            seen = 1'b1;
            check("collide_old", 32'(prev_v), 32'(old_v));
            check("collide_new", 32'(r_cell), 32'd8);
          end else begin
            prev_v = r_cell;
          end
        end
        check("done_seen", 32'(seen), 32'd1);
      end
    join
    check("seq_done_cnt", 32'(done_rise), 32'(exp_done));
    check_flags("seq");
    check_matrix("seq");

    // Random matrix with random inter-frame gaps
    for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b0, 1'b0, int'($urandom_range(0, 2)));
    check("rand_done_cnt", 32'(done_rise), 32'(exp_done));
    check_matrix("rand");

    // Parity fault: 0x03 with wrong parity, then 0x05 takes its slot
    send_frame(8'($urandom), 1'b0, 1'b0, 0);
    send_frame(8'($urandom), 1'b0, 1'b0, 0);
    send_frame(8'h03, 1'b1, 1'b0, 1);
    check_flags("parbad");
    send_frame(8'h05, 1'b0, 1'b0, 1);
    row = 1'b0;
    col = 2'd2;
    #1;
    check("par_slot", 32'(r_cell), 32'h05);
    @(negedge clk);
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b0, 1'b0, int'($urandom_range(0, 1)));
    check("par_done_cnt", 32'(done_rise), 32'(exp_done));
    check_flags("parend");
    check_matrix("par");

    // Framing error on 0xA5, line held low, then 0x5A
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    check_flags("frmbad");
    repeat (3 * TB_CPB) @(negedge clk);
    check("wait_high_busy", 32'(r_busy), 32'd1);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("wait_high_exit", 32'(r_busy), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1);
    check_flags("frmnext");
    check_matrix("frm");

    // One-cycle low glitch on idle line
    rx = 1'b0;
    model_start();
    @(negedge clk);
    rx = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (r_busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    check("glitch_busy_cycles", 32'(busy_cnt), 32'(TB_CPB / 2));
    check_flags("glitch");
    check_matrix("glitch");

    // Reset in the middle of the data bits of byte 3
    send_frame(8'($urandom), 1'b0, 1'b0, 0);
    send_frame(8'($urandom), 1'b0, 1'b0, 0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_busy", 32'(r_busy), 32'd0);
    check_flags("midrst");
    check_matrix("midrst");
    for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b0, 1'b0, int'($urandom_range(0, 2)));
    check("resend_done_cnt", 32'(done_rise), 32'(exp_done));
    check_matrix("resend");

    // Partial matrix, long idle, full matrix
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b0, 1'b0, 0);
    idle_bits(20);
    for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b0, 1'b0, 0);
    idle_bits(1);
    check("idle_done_cnt", 32'(done_rise), 32'(exp_done));
    check_flags("idle");
    check_matrix("idle");

    check("done_single_cycle", 32'(done_hi), 32'(done_rise));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
